ofm_write_arbiter: RTL and testbench
====================================

# ofm_write_arbiter

Round-robin write scheduler for the output-feature-map (OFM) store. It shares the single OFM write port (`address`, `wrData`, `wren`) between `NUM_LANES` filter/PE result streams. It places lane `i`'s k-th result at OFM row k, column i, and signals completion once every lane has written its configured row count. It sits between the PE array result outputs and the `Ofm` memory and drives that memory's write port directly.

## Interface

Parameters:
- `NUM_LANES`, 4: number of requesters; equals OFM column count; power of two.
- `DATA_W`, 8: result width; matches `wrData`.
- `ADDR_W`, 8: OFM address width.
- `ROW_W`, 6: row counter width; must equal `ADDR_W - log2(NUM_LANES)`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  one-cycle pulse; begins a layer pass; honoured only in IDLE.
- `rows_cfg`  in  ROW_W  rows per lane for this pass; sampled on accepted `start`.
- `req_valid`  in  NUM_LANES  per-lane result valid.
- `req_data`  in  NUM_LANES*DATA_W  per-lane result; lane i at bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_LANES  per-lane grant; one-hot or zero.
- `address`  out  ADDR_W  OFM write address, registered.
- `wrData`  out  DATA_W  OFM write data, registered.
- `wren`  out  1  OFM write enable, registered.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.

## Operation

FSM states:
- **IDLE**
  - `req_ready` is 0.
  - On `start`: latch `rows_cfg` into `rows_q`, clear all lane row pointers `row[i]`, set RR pointer to 0.
  - Go to RUN, or to DONE if `rows_cfg == 0`.
- **RUN**
  - Eligible lanes: `req_valid[i] && row[i] != rows_q`.
  - Grant the first eligible lane at or after the RR pointer, searching upward with wrap.
  - `req_ready[g]` is combinational (Mealy) in the same cycle; a handshake is `req_valid[g] && req_ready[g]`.
  - On handshake:
    - next cycle `address = row[g]*NUM_LANES + g` (row in upper `ROW_W` bits, lane in low bits), `wrData = req_data[g]`, `wren = 1`;
    - `row[g]` increments;
    - RR pointer becomes `(g+1) mod NUM_LANES`.
  - Cycles with no handshake: `wren = 0`; `address`/`wrData` hold their last value; RR pointer holds.
  - When the handshake completes the last lane's last row (all `row[i] == rows_q` after the update), go to DONE.
- **DONE**
  - `done = 1` for exactly one cycle, `req_ready` is 0, then go to IDLE.

Boundary conditions:
- A finished lane is never granted; its `req_valid` is ignored, and no OFM write beyond `rows_q` can occur.
- `start` in RUN or DONE is ignored; `rows_q` is unchanged.
- `rows_cfg` changes after the accepted `start` have no effect.
- Row pointers saturate at `rows_q`; they never wrap.
- Only one grant per cycle; the other valid lanes stall with `req_ready = 0` and must hold their data.
- Reset mid-pass: the pass is abandoned, the FSM returns to IDLE, all registers are cleared, and no partial-write cleanup is done.

## Timing

- Reset values:
  - `req_ready = 0`, `address = 0`, `wrData = 0`, `wren = 0`, `busy = 0`, `done = 0`;
  - state IDLE, RR pointer 0, all `row[i] = 0`, `rows_q = 0`.
- Accepted `start` at edge T: `busy = 1` from T+1; the first grant is possible in cycle T+1.
- Handshake in cycle C: `wren`/`address`/`wrData` valid in cycle C+1 (latency 1).
- Final handshake in cycle C: the last `wren` and `done = 1` both occur in C+1, with `busy = 0` in C+1; IDLE in C+2.
- `rows_cfg == 0` at `start` edge T: `done = 1` in T+1; no writes.
- Sustained throughput: one OFM write per cycle whenever any lane is eligible.

## Configuration

- `OFM_ARB_CNT_EN` defined:
  - adds output `wr_count` [ADDR_W:0], cleared on reset and on accepted `start`;
  - increments on every `wren` cycle, including the final one;
  - holds its value after `done` until the next `start`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan

- Reset then idle: `rst = 0` with `req_valid = 4'hF` → all outputs 0, `req_ready = 0`; after release with no `start`, no `wren`.
- Single lane: `rows_cfg = 3`, only lane 2 valid with data 8'h11, 8'h22, 8'h33, other lanes never valid → writes 8'h11/8'h22/8'h33 at addresses 2, 6, 10; no `done` while the other lanes are unfinished.
- Full contention: `rows_cfg = 2`, `req_valid = 4'hF` held →
  - grant order 0,1,2,3,0,1,2,3;
  - addresses 0–7 on consecutive cycles;
  - `done` coincides with the 8th `wren`, at handshake-cycle + 1;
  - `wr_count = 8` when `OFM_ARB_CNT_EN` is defined.
- Fairness: `rows_cfg = 4`, lanes 0 and 3 always valid, lanes 1 and 2 pulsed → after lane 3 is granted, lane 0 is granted next; no lane is granted twice while another eligible lane is waiting.
- Edge cases:
  - `rows_cfg = 0` → `done` one cycle after `start`, zero writes;
  - a second `start` with `rows_cfg = 9` during RUN → ignored, pass still ends at the original count.
- Reset mid-pass: assert `rst` low after 5 writes → outputs 0 immediately; a new `start` with `rows_cfg = 1` writes addresses 0–3.

Source files
------------

// File: rtl/ofm_write_arbiter.sv
// ofm_write_arbiter: round-robin scheduler that shares the single OFM write
// port between NUM_LANES result streams; lane i's k-th result lands at row k,
// column i, and done pulses once every lane has written rows_cfg rows.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start, rows_cfg layer-pass start pulse and rows per lane (taken in IDLE)
//   req_valid/data  per-lane results, lane i at [i*DATA_W +: DATA_W]
//   req_ready       per-lane grant, one-hot or zero, combinational
//   address/wrData  registered OFM write address/data
//   wren            registered OFM write enable
//   busy, done      pass in progress / one-cycle completion pulse
//   wr_count        writes issued this pass (only with OFM_ARB_CNT_EN)
//
// Optional feature macro: OFM_ARB_CNT_EN adds the wr_count output.

module ofm_write_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int ROW_W     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROW_W-1:0]            rows_cfg,
  input  logic [NUM_LANES-1:0]        req_valid,
  input  logic [NUM_LANES*DATA_W-1:0] req_data,
  output logic [NUM_LANES-1:0]        req_ready,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           wrData,
  output logic                        wren,
  output logic                        busy,
  output logic                        done
`ifdef OFM_ARB_CNT_EN
  ,
  output logic [ADDR_W:0]             wr_count
`endif
);

  localparam int LW = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] rows_q;
  logic [ROW_W-1:0] row [NUM_LANES];
  logic [LW-1:0]    rr;

  logic [NUM_LANES-1:0] elig;
  logic                 hit;
  logic                 hs;
  logic                 last;
  logic [LW-1:0]        g;
  logic [LW-1:0]        idx;
  logic [ROW_W-1:0]     row_g;
  logic [ROW_W-1:0]     row_inc;
  logic [DATA_W-1:0]    sel;

  // A lane that has written all its rows is never eligible again.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      elig[i] = req_valid[i] && (row[i] != rows_q);
    end
  end

  // First eligible lane at or after rr; the LW-bit sum wraps naturally.
  always_comb begin
    hit = 1'b0;
    g   = rr;
    idx = rr;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = rr + LW'(k);
      if (!hit && elig[idx]) begin
        hit = 1'b1;
        g   = idx;
      end
    end
  end

  assign hs = (state == S_RUN) && hit;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      req_ready[i] = hs && (g == LW'(i));
    end
  end

  always_comb begin
    row_g = '0;
    sel   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (g == LW'(i)) begin
        row_g = row[i];
        sel   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign row_inc = row_g + ROW_W'(1);

  // Pass is complete when every lane sits at rows_q after this handshake.
  always_comb begin
    last = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (g == LW'(i)) begin
        if (row_inc != rows_q) last = 1'b0;
      end else begin
        if (row[i] != rows_q) last = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rows_q  <= '0;
      rr      <= '0;
      address <= '0;
      wrData  <= '0;
      wren    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        row[i] <= '0;
      end
    end else begin
      wren <= 1'b0;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            rows_q <= rows_cfg;
            rr     <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
              row[i] <= '0;
            end
            if (rows_cfg == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (hs) begin
            address <= {row_g, g};
            wrData  <= sel;
            wren    <= 1'b1;
            row[g]  <= row_inc;
            rr      <= g + LW'(1);
            if (last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef OFM_ARB_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (state == S_IDLE && start) begin
      wr_count <= '0;
    end else if (hs) begin
      wr_count <= wr_count + (ADDR_W+1)'(1);
    end
  end
`endif

  a_onehot: assert property (
    @(posedge clk) disable iff (!rst) $onehot0(req_ready));

  a_no_grant_idle: assert property (
    @(posedge clk) disable iff (!rst)
    (state != S_RUN) |-> (req_ready == '0));

  a_done_not_busy: assert property (
    @(posedge clk) disable iff (!rst) done |-> !busy);

endmodule

// File: tb/tb_ofm_write_arbiter.sv
// tb_ofm_write_arbiter: randomized scoreboard bench for ofm_write_arbiter.
// Reference model is queue/array based; a monitor pops expected writes.

module tb_ofm_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [RW-1:0]   rows_cfg = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   address;
  logic [DW-1:0]   wrData;
  logic            wren;
  logic            busy;
  logic            done;
`ifdef OFM_ARB_CNT_EN
  logic [AW:0]     wr_count;
`endif

  always #5 clk = ~clk;

  ofm_write_arbiter #(
    .NUM_LANES(N),
    .DATA_W(DW),
    .ADDR_W(AW),
    .ROW_W(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rows_cfg(rows_cfg),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .address(address),
    .wrData(wrData),
    .wren(wren),
    .busy(busy),
`ifdef OFM_ARB_CNT_EN
    .wr_count(wr_count),
`endif
    .done(done)
  );

  typedef struct {
    int due;
    bit wr;
    int addr;
    int data;
    bit dn;
  } item_t;

  typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;

  item_t   sbq[$];
  int      total = 0;
  int      bad = 0;
  int      cyc = 0;

  mst_t    mst = M_IDLE;
  int      mrows = 0;
  int      mrow[N];
  int      mrr = 0;
  int      mwrites = 0;
  int      last_g = -1;
  logic [DW-1:0] ldata[N];
  logic [N-1:0]  gnt_obs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write/done the model scheduled must appear exactly then.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (rst) begin
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
          chk("missed_due", sbq[0].due, cyc);
          void'(sbq.pop_front());
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          it = sbq.pop_front();
          chk("wren", wren, it.wr);
          if (it.wr) begin
            chk("address", address, it.addr);
            chk("wrData", wrData, it.data);
          end
          chk("done", done, it.dn);
        end else begin
          chk("idle_wren", wren, 0);
          chk("idle_done", done, 0);
        end
      end
    end
  end

  // One cycle of stimulus plus the reference model's view of that cycle.
  task automatic step(input logic [N-1:0] v, input bit st, input int cfg);
    int g;
    bit fin;
    @(negedge clk);
    req_valid = v;
    start     = st;
    rows_cfg  = RW'(cfg);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = ldata[i];
    #1;
    g = -1;
    if (mst == M_RUN) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mrr + k) % N;
        if (g < 0 && v[i] && mrow[i] != mrows) g = i;
      end
    end
    gnt_obs = req_ready;
    chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("busy", busy, (mst == M_RUN));
    last_g = g;
    case (mst)
      M_IDLE: begin
        if (st) begin
          mrows   = cfg;
          mrr     = 0;
          mwrites = 0;
          for (int i = 0; i < N; i++) mrow[i] = 0;
          if (cfg == 0) begin
            sbq.push_back('{cyc + 1, 1'b0, 0, 0, 1'b1});
            mst = M_DONE;
          end else begin
            mst = M_RUN;
          end
        end
      end
      M_RUN: begin
        if (g >= 0) begin
          sbq.push_back('{cyc + 1, 1'b1, mrow[g] * N + g, int'(ldata[g]), 1'b0});
          mrow[g]++;
          mrr = (g + 1) % N;
          mwrites++;
          fin = 1'b1;
          for (int i = 0; i < N; i++) if (mrow[i] != mrows) fin = 1'b0;
          sbq[sbq.size()-1].dn = fin;
          ldata[g] = DW'($urandom);
          if (fin) mst = M_DONE;
        end
      end
      default: mst = M_IDLE;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst       = 1'b0;
    start     = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_wren", wren, 0);
    chk("rst_address", address, 0);
    chk("rst_wrData", wrData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef OFM_ARB_CNT_EN
    chk("rst_wr_count", wr_count, 0);
`endif
    sbq.delete();
    mst   = M_IDLE;
    mrows = 0;
    mrr   = 0;
    for (int i = 0; i < N; i++) mrow[i] = 0;
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic run_until_idle(input logic [N-1:0] v);
    int n;
    n = 0;
    while (mst != M_IDLE && n < 300) begin
      step(v, 1'b0, 0);
      n++;
    end
    chk("pass_end_bound", (mst == M_IDLE), 1);
  endtask

  task automatic check_count();
`ifdef OFM_ARB_CNT_EN
    chk("wr_count", wr_count, mwrites);
`endif
  endtask

  initial begin
    int n;
    int cfg;
    logic [N-1:0] v;
    logic [DW-1:0] vals [3];
    vals[0] = 8'h11;
    vals[1] = 8'h22;
    vals[2] = 8'h33;
    for (int i = 0; i < N; i++) ldata[i] = DW'($urandom);
    for (int i = 0; i < N; i++) mrow[i] = 0;

    do_reset();
    repeat (5) step('1, 1'b0, 0);

    // single lane 2, three rows
    step('0, 1'b1, 3);
    for (int k = 0; k < 3; k++) begin
      ldata[2] = vals[k];
      n = 0;
      do begin
        step(4'b0100, 1'b0, 0);
        n++;
      end while (last_g != 2 && n < 10);
      chk("lane2_granted", last_g, 2);
    end
    repeat (4) step(4'b0100, 1'b0, 0);
    chk("lane2_still_busy", busy, 1);
    run_until_idle(4'b1011);

    // full contention, two rows
    step('0, 1'b1, 2);
    for (int k = 0; k < 8; k++) begin
      step('1, 1'b0, 0);
      chk("rr_order", gnt_obs, 64'd1 << (k % N));
    end
    run_until_idle('1);
    repeat (2) step('0, 1'b0, 0);
    check_count();

    // fairness: lanes 0,3 always valid, 1,2 pulsed
    step('0, 1'b1, 4);
    n = 0;
    while (mst != M_IDLE && n < 200) begin
      v = {1'b1, 1'($urandom), 1'($urandom), 1'b1};
      step(v, 1'b0, 0);
      n++;
    end
    chk("fair_end", (mst == M_IDLE), 1);

    // zero rows
    step('1, 1'b1, 0);
    step('1, 1'b0, 0);
    step('1, 1'b0, 0);

    // restart ignored while running
    step('0, 1'b1, 2);
    step('1, 1'b1, 9);
    step('1, 1'b1, 9);
    run_until_idle('1);
    repeat (2) step('0, 1'b0, 0);
    check_count();

    // reset after five writes, then a one-row pass
    step('0, 1'b1, 2);
    n = 0;
    while (mwrites < 5 && n < 20) begin
      step('1, 1'b0, 0);
      n++;
    end
    do_reset();
    step('0, 1'b1, 1);
    run_until_idle('1);
    repeat (2) step('0, 1'b0, 0);
    check_count();

    // randomized passes with stray starts
    for (int p = 0; p < 20; p++) begin
      cfg = int'($urandom_range(0, 6));
      step(N'($urandom), 1'b1, cfg);
      n = 0;
      while (mst != M_IDLE && n < 400) begin
        step(N'($urandom), ($urandom_range(0, 9) == 0), 9);
        n++;
      end
      chk("rand_end", (mst == M_IDLE), 1);
      repeat (2) step('0, 1'b0, 0);
      check_count();
    end

    repeat (3) step('0, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
